mux4to1_triple: RTL and testbench
=================================

Name: mux4to1_triple

Overview:
- 4-to-1 multiplexer built three ways in parallel, as a cross-checked select element.
- Implementations:
  - structural: primitive AND/OR/NOT gate instances;
  - behavioural: if/else-if chain;
  - behavioural: case statement.
- All three combinational outputs are exposed. A registered output and a registered disagreement flag are added for use in clocked datapaths and self-check logic.

Parameters:
- WIDTH, 1, bit width of each data input and of each data output. Selection is applied bitwise across the whole vector.

Ports:
- clk  input  1  rising-edge clock for the registered outputs
- rst  input  1  asynchronous, active-high reset
- in0  input  WIDTH  data input, selected when sel=2'b00
- in1  input  WIDTH  data input, selected when sel=2'b01
- in2  input  WIDTH  data input, selected when sel=2'b10
- in3  input  WIDTH  data input, selected when sel=2'b11
- sel  input  2  select; sel[1] is the MSB
- out_inst  output  WIDTH  combinational result, gate-instance implementation
- out_if  output  WIDTH  combinational result, if/else implementation
- out_case  output  WIDTH  combinational result, case implementation
- out_q  output  WIDTH  registered copy of out_case
- mismatch  output  1  registered flag: combinational results disagree

Behaviour:
- Select map, identical for all three implementations:
  - sel=00 -> in0
  - sel=01 -> in1
  - sel=10 -> in2
  - sel=11 -> in3
- Combinational outputs: zero latency and no state. They settle within the same delta/evaluation as an input change.
- Structural implementation:
  - per bit, out = (~s1&~s0&in0) | (~s1&s0&in1) | (s1&~s0&in2) | (s1&s0&in3);
  - built only from primitive not/and/or instances;
  - no procedural code and no ?: operator.
- If implementation:
  - combinational always block, chain sel==0 / ==1 / ==2 / else;
  - out is assigned on every path, so no latch is inferred.
- Case implementation:
  - combinational always block, four explicit items;
  - default item drives all zeros (covers X/Z sel in simulation).
- out_q:
  - on each rising clk edge, out_q <= out_case;
  - 1-cycle latency from a stable input to out_q.
- mismatch:
  - on each rising clk edge, mismatch <= (out_inst != out_if) | (out_if != out_case);
  - must read 0 for every legal input combination.
- Reset:
  - while rst=1, out_q=0 and mismatch=0, immediately and independent of clk;
  - release takes effect at the first rising clk after rst falls.
  - Asserting reset mid-operation clears both registers at once.
- rst does not affect the combinational outputs.
- Simultaneous input and sel changes: no glitch requirement on combinational outputs; registered outputs sample the settled values.
- WIDTH>1: every bit is selected with the same sel; no bit mixing between inputs.

Test Plan:
- All zeros: sel=00, in3..in0=0000 -> out_inst=out_if=out_case=0; mismatch=0.
- sel=01, in3..in0=1010 -> all three outputs =1 (in1); sel=00, in3..in0=0111 -> all =1 (in0).
- sel=10, in3..in0=0000 -> all =0; sel=10, in3..in0=1110 -> all =1 (in2).
- sel=11, in3..in0=1111 -> all =1. Sel=00 with in3..in0=0011 or 0101 -> all =1.
- Exhaustive sweep of all 64 {sel,in3..in0} combinations at WIDTH=1:
  - each output equals in[sel];
  - mismatch stays 0;
  - out_q equals the previous cycle's out_case.
- Reset:
  - assert rst asynchronously between clock edges while out_q=1 -> out_q drops to 0 without a clock edge;
  - release, then sel=11, in3=1 -> out_q=1 after one rising edge.

Source files
------------

// File: rtl/mux4to1_triple.sv
// rtl/mux4to1_triple.sv - 4-to-1 select built three ways (gates, if-chain, case)
// with a registered result and a registered cross-check disagreement flag.
module mux4to1_triple #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out_inst,
    output logic [WIDTH-1:0] out_if,
    output logic [WIDTH-1:0] out_case,
    output logic [WIDTH-1:0] out_q,
    output logic             mismatch
);

    wire             s1_n;
    wire             s0_n;
    wire [WIDTH-1:0] inst_w;

    not u_not_s1 (s1_n, sel[1]);
    not u_not_s0 (s0_n, sel[0]);

    // One sum-of-products per bit; the decoded select terms are shared by all bits.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        wire t0, t1, t2, t3;
        and u_and0 (t0, s1_n,   s0_n,   in0[i]);
        and u_and1 (t1, s1_n,   sel[0], in1[i]);
        and u_and2 (t2, sel[1], s0_n,   in2[i]);
        and u_and3 (t3, sel[1], sel[0], in3[i]);
        or  u_or   (inst_w[i], t0, t1, t2, t3);
    end

    assign out_inst = inst_w;

    always_comb begin
        if (sel == 2'd0) begin
            out_if = in0;
        end else if (sel == 2'd1) begin
            out_if = in1;
        end else if (sel == 2'd2) begin
            out_if = in2;
        end else begin
            out_if = in3;
        end
    end

    // Default drives zeros so an X/Z select is visible rather than silently mapped.
    always_comb begin
        case (sel)
            2'b00:   out_case = in0;
            2'b01:   out_case = in1;
            2'b10:   out_case = in2;
            2'b11:   out_case = in3;
            default: out_case = '0;
        endcase
    end

    logic [WIDTH-1:0] out_q_d;
    logic [WIDTH-1:0] out_q_q;
    logic             mismatch_d;
    logic             mismatch_q;

    always_comb begin
        out_q_d    = out_case;
        mismatch_d = (out_inst != out_if) | (out_if != out_case);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q_q    <= '0;
            mismatch_q <= 1'b0;
        end else begin
            out_q_q    <= out_q_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign out_q    = out_q_q;
    assign mismatch = mismatch_q;

endmodule

// File: tb/tb_mux4to1_triple.sv
// tb/tb_mux4to1_triple.sv - randomized and directed checks of mux4to1_triple
// against an array-indexed reference select.
`timescale 1ns/1ps
module tb_mux4to1_triple;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sel;
    logic       in0, in1, in2, in3;
    logic       out_inst, out_if, out_case, out_q, mismatch;

    logic [7:0] w0, w1, w2, w3;
    logic [1:0] wsel;
    logic [7:0] w_inst, w_if, w_case, w_q;
    logic       w_mismatch;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux4to1_triple #(.WIDTH(1)) dut (
        .clk(clk), .rst(rst),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3), .sel(sel),
        .out_inst(out_inst), .out_if(out_if), .out_case(out_case),
        .out_q(out_q), .mismatch(mismatch)
    );

    mux4to1_triple #(.WIDTH(8)) dut_w (
        .clk(clk), .rst(rst),
        .in0(w0), .in1(w1), .in2(w2), .in3(w3), .sel(wsel),
        .out_inst(w_inst), .out_if(w_if), .out_case(w_case),
        .out_q(w_q), .mismatch(w_mismatch)
    );

    function automatic logic ref_bit(input logic [1:0] s, input logic [3:0] ins);
        return ins[s];
    endfunction

    function automatic logic [7:0] ref_vec(input logic [1:0] s, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] c,
                                           input logic [7:0] d);
        logic [7:0] tbl [4];
        tbl[0] = a; tbl[1] = b; tbl[2] = c; tbl[3] = d;
        return tbl[s];
    endfunction

    task automatic drive(input logic [1:0] s, input logic [3:0] ins);
        @(negedge clk);
        sel = s;
        {in3, in2, in1, in0} = ins;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sel = 2'b11; {in3, in2, in1, in0} = 4'b1111;
        wsel = 2'b00; w0 = 8'hff; w1 = 8'h00; w2 = 8'h00; w3 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_q, mismatch} !== 2'b00) begin
            errors++;
            $display("FAIL reset_regs out_q=%b mismatch=%b expected 0 0", out_q, mismatch);
        end
        checks++;
        if ({w_q, w_mismatch} !== 9'h0) begin
            errors++;
            $display("FAIL reset_wide out_q=%h mismatch=%b expected 00 0", w_q, w_mismatch);
        end
        checks++;
        if ({out_inst, out_if, out_case} !== 3'b111) begin
            errors++;
            $display("FAIL reset_comb outs=%b expected 111", {out_inst, out_if, out_case});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [5:0] vec [8];
        logic e;
        vec = '{6'b00_0000, 6'b01_1010, 6'b00_0111, 6'b10_0000,
                6'b10_1110, 6'b11_1111, 6'b00_0011, 6'b00_0101};
        for (int i = 0; i < 8; i++) begin
            drive(vec[i][5:4], vec[i][3:0]);
            e = ref_bit(vec[i][5:4], vec[i][3:0]);
            #1;
            checks++;
            if ({out_inst, out_if, out_case} !== {3{e}}) begin
                errors++;
                $display("FAIL directed_%0d sel=%b ins=%b outs=%b expected %b", i,
                         vec[i][5:4], vec[i][3:0], {out_inst, out_if, out_case}, {3{e}});
            end
            @(posedge clk); #1;
            checks++;
            if ({out_q, mismatch} !== {e, 1'b0}) begin
                errors++;
                $display("FAIL directed_reg_%0d out_q=%b mismatch=%b expected %b 0",
                         i, out_q, mismatch, e);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic e;
        logic prev;
        prev = out_q;
        for (int k = 0; k < 64; k++) begin
            drive(k[5:4], k[3:0]);
            e = ref_bit(k[5:4], k[3:0]);
            #1;
            checks++;
            if ({out_inst, out_if, out_case, out_q} !== {e, e, e, prev}) begin
                errors++;
                $display("FAIL sweep_%0d outs=%b out_q=%b expected %b out_q=%b",
                         k, {out_inst, out_if, out_case}, out_q, {3{e}}, prev);
            end
            @(posedge clk); #1;
            checks++;
            if ({out_q, mismatch} !== {e, 1'b0}) begin
                errors++;
                $display("FAIL sweep_reg_%0d out_q=%b mismatch=%b expected %b 0",
                         k, out_q, mismatch, e);
            end
            prev = e;
        end
    endtask

    task automatic test_random_wide();
        logic [7:0] e;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            wsel = 2'($urandom_range(0, 3));
            w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom); w3 = 8'($urandom);
            e = ref_vec(wsel, w0, w1, w2, w3);
            #1;
            checks++;
            if ({w_inst, w_if, w_case} !== {e, e, e}) begin
                errors++;
                $display("FAIL wide_%0d sel=%0d inst=%h if=%h case=%h expected %h",
                         k, wsel, w_inst, w_if, w_case, e);
            end
            @(posedge clk); #1;
            checks++;
            if ({w_q, w_mismatch} !== {e, 1'b0}) begin
                errors++;
                $display("FAIL wide_reg_%0d out_q=%h mismatch=%b expected %h 0",
                         k, w_q, w_mismatch, e);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(2'b11, 4'b1000);
        @(posedge clk); #1;
        checks++;
        if (out_q !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset out_q=%b expected 1", out_q);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_q, mismatch} !== 2'b00) begin
            errors++;
            $display("FAIL async_reset out_q=%b mismatch=%b expected 0 0", out_q, mismatch);
        end
        checks++;
        if ({out_inst, out_if, out_case} !== 3'b111) begin
            errors++;
            $display("FAIL reset_no_comb_effect outs=%b expected 111",
                     {out_inst, out_if, out_case});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_q !== 1'b0) begin
            errors++;
            $display("FAIL release_before_edge out_q=%b expected 0", out_q);
        end
        @(posedge clk); #1;
        checks++;
        if (out_q !== 1'b1) begin
            errors++;
            $display("FAIL release_after_edge out_q=%b expected 1", out_q);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_exhaustive();
        test_random_wide();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
